// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction fetch stage.
package fetch_unit_pkg;

   localparam int unsigned XLEN_DEF     = 32;
   localparam logic [31:0] NOP_INST     = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

   // Queue occupancy counter width for a given power-of-two depth.
   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// Prefetch queue: synchronous FIFO with flush, DEPTH entries of WIDTH bits.
module fetch_fifo
   import fetch_unit_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 64,
   localparam int unsigned AW   = $clog2(DEPTH),
   localparam int unsigned CW   = cnt_width(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign count = count_q;
   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));
   assign dout  = mem_q[rd_ptr_q];

   // Pointer/count/storage update; flush discards everything queued.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      do_push  = push & ~full;
      do_pop   = pop & ~empty;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   // Control state register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   push_while_full: assert property (@(posedge clk) disable iff (!reset)
      !(push && full && !flush));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues 1-cycle-latency
// imem requests, buffers responses and hands them to Decode.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int unsigned      XLEN     = XLEN_DEF,
   parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEF),
   parameter int unsigned      DEPTH    = 2
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic [31:0]     imem_rdata,
   input  logic            jump_flag,
   input  logic [XLEN-1:0] jump_target,
   input  logic            id_ready,
   output logic            id_valid,
   output logic [XLEN-1:0] id_pc,
   output logic [31:0]     id_inst
);

   localparam int unsigned CW = cnt_width(DEPTH);
   localparam int unsigned EW = XLEN + 32;

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
   logic [XLEN-1:0] last_pc_q, last_pc_d;
   logic            inflight_valid_q, inflight_valid_d;

   logic            push, pop, q_full, q_empty, credit;
   logic [CW-1:0]   q_count;
   logic [CW:0]     occ;
   logic [EW-1:0]   q_head;
   logic [XLEN-1:0] head_pc;
   logic [31:0]     head_inst;

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .flush (jump_flag),
      .din   ({inflight_pc_q, imem_rdata}),
      .dout  (q_head),
      .full  (q_full),
      .empty (q_empty),
      .count (q_count)
   );

   assign head_pc   = q_head[EW-1:32];
   assign head_inst = q_head[31:0];

   // Handshake and request control; credit counts the in-flight fetch so
   // the queue can never be overrun by a response.
   always_comb begin
      id_valid  = reset & ~q_empty & ~jump_flag;
      pop       = id_valid & id_ready;
      push      = inflight_valid_q & ~jump_flag;
      imem_addr = jump_flag ? {jump_target[XLEN-1:2], 2'b00} : fetch_pc_q;
      occ       = {1'b0, q_count} + (CW+1)'(inflight_valid_q) - (CW+1)'(pop);
      credit    = (occ < (CW+1)'(DEPTH));
      imem_req  = reset & (jump_flag | credit);
   end

   // Decode-facing data: NOP when nothing is queued or in reset.
   always_comb begin
      if (!reset) begin
         id_pc   = '0;
         id_inst = NOP_INST;
      end else if (q_empty) begin
         id_pc   = last_pc_q;
         id_inst = NOP_INST;
      end else begin
         id_pc   = head_pc;
         id_inst = head_inst;
      end
   end

   // Next-state for PC, in-flight tracking and the last presented PC.
   always_comb begin
      fetch_pc_d       = imem_req ? (imem_addr + XLEN'(4)) : fetch_pc_q;
      inflight_valid_d = imem_req;
      inflight_pc_d    = imem_addr;
      last_pc_d        = q_empty ? last_pc_q : head_pc;
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         fetch_pc_q       <= RESET_PC;
         inflight_valid_q <= 1'b0;
         inflight_pc_q    <= '0;
         last_pc_q        <= '0;
      end else begin
         fetch_pc_q       <= fetch_pc_d;
         inflight_valid_q <= inflight_valid_d;
         inflight_pc_q    <= inflight_pc_d;
         last_pc_q        <= last_pc_d;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table plus multi-cycle sequences.
module tb_fetch_unit;

   localparam logic [31:0] KEY = 32'hA5A5_0000;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset, imem_req, jump_flag, id_ready, id_valid;
   logic [31:0] imem_addr, imem_rdata, jump_target, id_pc, id_inst;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Synchronous instruction memory, 1-cycle latency.
   always @(posedge clk) imem_rdata <= imem_addr ^ KEY;

   fetch_unit #(
      .XLEN     (32),
      .RESET_PC (32'h0000_0000),
      .DEPTH    (2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .jump_flag   (jump_flag),
      .jump_target (jump_target),
      .id_ready    (id_ready),
      .id_valid    (id_valid),
      .id_pc       (id_pc),
      .id_inst     (id_inst)
   );

   typedef struct {
      logic        rst;
      logic        jf;
      logic [31:0] jt;
      logic        rdy;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_pc;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic jf, input logic [31:0] jt, input logic rdy);
      reset       = rst;
      jump_flag   = jf;
      jump_target = jt;
      id_ready    = rdy;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic rst, input logic jf, input logic [31:0] jt, input logic rdy,
                      input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                      input logic [31:0] e_pc);
      vec_t v;
      v.rst = rst; v.jf = jf; v.jt = jt; v.rdy = rdy;
      v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
      vecs.push_back(v);
   endtask

   initial begin
      logic [31:0] exp_next;
      int          pops;

      drive(1'b0, 1'b0, 32'h0, 1'b1);
      tick();

      // reset, stream, jump to 0x100, misaligned jump, wrap at top of memory
      add(0, 0, 32'h0,        1, 0, 32'h0000_0000, 0, 32'h0);
      add(1, 0, 32'h0,        1, 1, 32'h0000_0000, 0, 32'h0);
      add(1, 0, 32'h0,        1, 1, 32'h0000_0004, 0, 32'h0);
      add(1, 0, 32'h0,        1, 1, 32'h0000_0008, 1, 32'h0000_0000);
      add(1, 0, 32'h0,        1, 1, 32'h0000_000C, 1, 32'h0000_0004);
      add(1, 0, 32'h0,        1, 1, 32'h0000_0010, 1, 32'h0000_0008);
      add(1, 1, 32'h100,      1, 1, 32'h0000_0100, 0, 32'h0);
      add(1, 0, 32'h0,        1, 1, 32'h0000_0104, 0, 32'h0);
      add(1, 0, 32'h0,        1, 1, 32'h0000_0108, 1, 32'h0000_0100);
      add(1, 1, 32'h103,      1, 1, 32'h0000_0100, 0, 32'h0);
      add(1, 0, 32'h0,        1, 1, 32'h0000_0104, 0, 32'h0);
      add(1, 0, 32'h0,        1, 1, 32'h0000_0108, 1, 32'h0000_0100);
      add(1, 0, 32'h0,        1, 1, 32'h0000_010C, 1, 32'h0000_0104);
      add(1, 1, 32'hFFFF_FFFC, 1, 1, 32'hFFFF_FFFC, 0, 32'h0);
      add(1, 0, 32'h0,        1, 1, 32'h0000_0000, 0, 32'h0);
      add(1, 0, 32'h0,        1, 1, 32'h0000_0004, 1, 32'hFFFF_FFFC);
      add(1, 0, 32'h0,        1, 1, 32'h0000_0008, 1, 32'h0000_0000);

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].jf, vecs[i].jt, vecs[i].rdy);
         @(negedge clk);
         chk($sformatf("v%0d_req", i),   32'(imem_req),  32'(vecs[i].e_req));
         chk($sformatf("v%0d_addr", i),  imem_addr,      vecs[i].e_addr);
         chk($sformatf("v%0d_valid", i), 32'(id_valid),  32'(vecs[i].e_valid));
         if (vecs[i].e_valid) begin
            chk($sformatf("v%0d_pc", i),   id_pc,   vecs[i].e_pc);
            chk($sformatf("v%0d_inst", i), id_inst, vecs[i].e_pc ^ KEY);
         end
         if (!vecs[i].rst) begin
            chk($sformatf("v%0d_rst_pc", i),   id_pc,   32'h0);
            chk($sformatf("v%0d_rst_inst", i), id_inst, NOP);
         end
         tick();
      end

      // Backpressure: stream to C3, stall 6 cycles, then resume.
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      tick();
      exp_next = 32'h0;
      pops     = 0;
      for (int c = 0; c < 15; c++) begin
         drive(1'b1, 1'b0, 32'h0, (c >= 3 && c < 9) ? 1'b0 : 1'b1);
         @(negedge clk);
         if (c >= 3 && c < 9) begin
            chk($sformatf("bp_c%0d_req", c),   32'(imem_req), 32'h0);
            chk($sformatf("bp_c%0d_valid", c), 32'(id_valid), 32'h1);
            chk($sformatf("bp_c%0d_pc", c),    id_pc,         32'h4);
         end
         if (id_valid && id_ready) begin
            chk($sformatf("bp_c%0d_pc", c),   id_pc,   exp_next);
            chk($sformatf("bp_c%0d_inst", c), id_inst, exp_next ^ KEY);
            exp_next = exp_next + 32'h4;
            pops++;
         end
         tick();
      end
      chk("bp_pops", 32'(pops), 32'd7);

      // Jump while full and stalled.
      for (int c = 0; c < 3; c++) begin
         drive(1'b1, 1'b0, 32'h0, 1'b0);
         tick();
      end
      drive(1'b1, 1'b1, 32'h200, 1'b0);
      @(negedge clk);
      chk("jf_req",   32'(imem_req), 32'h1);
      chk("jf_addr",  imem_addr,     32'h200);
      chk("jf_valid", 32'(id_valid), 32'h0);
      tick();
      drive(1'b1, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chk("jf1_valid", 32'(id_valid), 32'h0);
      chk("jf1_inst",  id_inst,       NOP);
      chk("jf1_addr",  imem_addr,     32'h204);
      tick();
      @(negedge clk);
      chk("jf2_valid", 32'(id_valid), 32'h1);
      chk("jf2_pc",    id_pc,         32'h200);
      chk("jf2_inst",  id_inst,       32'h200 ^ KEY);
      tick();

      // One-cycle reset mid-stream, then refetch from RESET_PC.
      drive(1'b1, 1'b0, 32'h0, 1'b1);
      tick();
      tick();
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      chk("mr_req",   32'(imem_req), 32'h0);
      chk("mr_valid", 32'(id_valid), 32'h0);
      chk("mr_pc",    id_pc,         32'h0);
      chk("mr_inst",  id_inst,       NOP);
      tick();
      drive(1'b1, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      chk("mr_c0_addr",  imem_addr,     32'h0);
      chk("mr_c0_valid", 32'(id_valid), 32'h0);
      tick();
      @(negedge clk);
      chk("mr_c1_valid", 32'(id_valid), 32'h0);
      tick();
      @(negedge clk);
      chk("mr_c2_valid", 32'(id_valid), 32'h1);
      chk("mr_c2_pc",    id_pc,         32'h0);
      chk("mr_c2_inst",  id_inst,       KEY);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction Fetch stage feeding the Decode pipeline register. It owns the fetch PC and issues requests to the synchronous instruction memory, which has 1-cycle read latency. Responses are buffered in a small prefetch queue and handed to Decode over a valid/ready handshake. Jump redirects coming back from Execute flush both in-flight and queued fetches.

Parameters:
- XLEN, 32, datapath and address width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 2, prefetch queue entries; legal values 2..8, power of 2.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset; 0 at a posedge resets the block.
- imem_req  out  1  fetch request this cycle.
- imem_addr  out  XLEN  fetch address; word aligned.
- imem_rdata  in  32  instruction word; valid the cycle after imem_req.
- jump_flag  in  1  redirect from Execute.
- jump_target  in  XLEN  redirect address.
- id_ready  in  1  Decode can accept an instruction.
- id_valid  out  1  id_pc and id_inst are valid.
- id_pc  out  XLEN  PC of the head instruction.
- id_inst  out  32  head instruction word.

Behaviour:
- Reset (reset==0 at posedge):
  - fetch_pc <= RESET_PC, queue emptied, inflight_valid <= 0.
  - While reset==0: imem_req=0, id_valid=0, id_pc=0, id_inst=32'h0000_0013 (NOP).
- Address: imem_addr = jump_flag ? {jump_target[XLEN-1:2],2'b00} : fetch_pc. Low two bits of jump_target are forced to 0.
- Pop: pop = id_valid & id_ready.
- Credit: credit = (count + inflight_valid - pop) < DEPTH.
- Request: imem_req = reset & (jump_flag | credit).
  - When imem_req=1: fetch_pc <= imem_addr + 4, mod 2^XLEN, so 0xFFFF_FFFC wraps to 0.
  - Also inflight_valid <= imem_req and inflight_pc <= imem_addr every cycle.
- Response: if inflight_valid & !jump_flag, push {inflight_pc, imem_rdata}. Credit guarantees no overflow. A push while full is an assertion failure.
- Output:
  - id_valid = !empty & !jump_flag; id_pc/id_inst = head entry.
  - When empty, id_pc/id_inst hold NOP and the last PC.
  - Only the head is popped on pop. Simultaneous push and pop keeps count unchanged.
- Jump cycle:
  - Queue is cleared and the response for the previous cycle's request is dropped.
  - A request to the target is issued in the same cycle, regardless of id_ready or fullness.
- Latency:
  - First cycle with reset=1 is C0: request RESET_PC; id_valid=1 with id_pc=RESET_PC in C2.
  - Jump in cycle J: target instruction presented in J+2; id_valid=0 in J and J+1.
- Throughput: with id_ready held 1, one instruction per cycle sustained at DEPTH=2.
- Backpressure:
  - id_ready=0: queue fills, then imem_req=0.
  - id_pc/id_inst stay stable while id_valid & !id_ready and no jump.
  - No instruction is lost or duplicated.
- Priority: reset > jump_flag > normal fetch.
- Combinational paths: jump_flag and id_ready to imem_req/imem_addr/id_valid are permitted; no path from imem_rdata to any output.

Decomposition:
- Shared header (with existing defines): NOP_INST = 32'h0000_0013, XLEN, default RESET_PC.
- Sub-module fetch_fifo: synchronous FIFO, DEPTH x (XLEN+32), ports push/pop/flush/full/empty/count, synchronous active-low reset. Pointer wrap uses log2(DEPTH) bits plus a count register of width log2(DEPTH)+1.

Test Plan:
1. Reset release, id_ready=1, memory model returns rdata=addr^32'hA5A5_0000: id_valid first in C2, id_pc = 0,4,8,... one per cycle, each id_inst matching its PC.
2. Backpressure, id_ready=0 from C3 for 6 cycles: at most DEPTH entries plus one in flight; imem_req low while stalled. After release, id_pc continues contiguously with no gap or repeat.
3. Jump in cycle J with target 0x100 while streaming: id_valid=0 in J and J+1, then id_pc=0x100, 0x104 from J+2. No stale PC ever appears.
4. Jump with target 0x0000_0103: imem_addr=0x100 in J; id_pc=0x100 at J+2.
5. Jump while queue full and id_ready=0: imem_req=1 with addr=target in J; queue empty in J+1.
6. Reset low for 1 cycle mid-stream: id_valid=0 and id_inst=NOP during reset. After release, refetch starts at RESET_PC with id_valid in C2. Also fetch from 0xFFFF_FFFC: next request is 0x0.
